ysyx_22050019_axi_rd_arbiter: RTL and testbench
===============================================

Name: ysyx_22050019_axi_rd_arbiter

Overview:
- Two-requester read-channel arbiter that shares the single AXI read port toward memory between the icache refill path (requester 0) and the dcache refill path (requester 1).
- Accepts one burst request at a time, drives it downstream, and routes all returning beats to the granted requester. Beat counting is internal and derived from the burst length.
- Round-robin between the two requesters. Sits between the caches and the top-level AXI crossbar.

Parameters:
- ADDR_WIDTH, 32, address width of all ar channels
- DATA_WIDTH, 64, r data width
- LEN_WIDTH, 8, burst length field width (beats = len+1); narrower cache len fields are zero-extended at integration

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_ar_valid_i  in  2  per-requester address valid (bit0 icache, bit1 dcache)
- s_ar_ready_o  out  2  per-requester address ready
- s_ar_addr0_i  in  ADDR_WIDTH  requester 0 address
- s_ar_addr1_i  in  ADDR_WIDTH  requester 1 address
- s_ar_len0_i  in  LEN_WIDTH  requester 0 burst length
- s_ar_len1_i  in  LEN_WIDTH  requester 1 burst length
- s_r_ready_i  in  2  per-requester data ready
- s_r_valid_o  out  2  per-requester data valid
- s_r_last_o  out  2  per-requester last beat (from internal count)
- s_r_resp_o  out  2  response, broadcast to both requesters
- s_r_data_o  out  DATA_WIDTH  data, broadcast to both requesters
- m_ar_valid_o  out  1  downstream address valid
- m_ar_ready_i  in  1  downstream address ready
- m_ar_addr_o  out  ADDR_WIDTH  downstream address
- m_ar_len_o  out  LEN_WIDTH  downstream burst length
- m_r_valid_i  in  1  downstream data valid
- m_r_ready_o  out  1  downstream data ready
- m_r_resp_i  in  2  downstream response
- m_r_data_i  in  DATA_WIDTH  downstream data
- m_r_last_i  in  1  downstream last (checked only)
- proto_err_o  out  1  one-cycle pulse on last/count mismatch

Behaviour:
- Reset values: state=IDLE, grant=0, prio_last=1 (so requester 0 wins the first tie), addr/len/cnt regs=0. All outputs 0: s_ar_ready_o=0, s_r_valid_o=0, s_r_last_o=0, m_ar_valid_o=0, m_r_ready_o=0, proto_err_o=0. A reset asserted mid-transaction returns to IDLE, drops the burst, and does not drain outstanding beats.
- States: IDLE, AR, R.
- IDLE, winner selection:
  - Only one valid: that requester wins.
  - Both valid: the requester other than prio_last wins.
  - s_ar_ready_o[winner]=1 combinationally in IDLE only; the loser sees 0.
- IDLE, on winner handshake: latch grant, addr, len; cnt<=len; next state AR. No valid: stay IDLE.
- AR:
  - m_ar_valid_o=1 with the registered addr/len, held stable until m_ar_ready_i.
  - On handshake go to R. Minimum latency: upstream handshake at cycle N gives m_ar_valid_o at N+1.
- R:
  - s_r_valid_o[grant]=m_r_valid_i; the other bit stays 0.
  - m_r_ready_o=s_r_ready_i[grant].
  - s_r_data_o/s_r_resp_o pass m_r_data_i/m_r_resp_i through combinationally.
  - s_r_last_o[grant]=(cnt==0)&m_r_valid_i.
- R, per beat: on each m_r_valid_i&m_r_ready_o, if cnt!=0 then cnt<=cnt-1.
- R, final beat (cnt==0): prio_last<=grant, state<=IDLE. The next grant is possible in the cycle after the last beat (no combinational IDLE grant in that same cycle).
- Non-OKAY resp: passed through unchanged. The burst is not aborted and the count continues.
- proto_err_o: pulses 1 on any accepted beat where m_r_last_i != (cnt==0). This is detect-only; the internal count always governs completion.
- Ungranted requester valid held across a whole burst: it stays pending. It is guaranteed the next grant because priority rotates after every completed burst, so neither requester can be starved.
- len=0 (single beat): R completes on the first beat.
- len=2^LEN_WIDTH-1: cnt counts the full range with no wrap before completion.
- Requester deasserting ar_valid in IDLE before the handshake: no grant, no state change.

Test Plan:
- Single icache request, addr=0x8000_0010, len=1, m_ar_ready_i=1 immediately, two beats with data 0xA, 0xB → m_ar_addr_o=0x8000_0010 and m_ar_len_o=1 one cycle after the handshake; s_r_valid_o=2'b01 on both beats; s_r_last_o[0]=1 only on 0xB; FSM back in IDLE the next cycle.
- Both requesters valid out of reset (addr0=0x100, addr1=0x200, len=0) → icache granted first, then dcache granted after icache's beat completes. With both held continuously valid, grants alternate 0,1,0,1.
- Backpressure: s_r_ready_i[1]=0 for 3 cycles during a dcache len=3 burst → m_r_ready_o=0 for those cycles, no beat lost, 4 beats total delivered, last only on the 4th.
- m_ar_ready_i held low for 5 cycles → m_ar_valid_o stays 1 with stable addr/len; s_ar_ready_o=0 for both requesters throughout.
- Downstream asserts m_r_last_i on beat 1 of a len=1 burst → proto_err_o pulses once; the arbiter still waits for beat 2 before returning to IDLE.
- rst asserted during R mid-burst → next cycle all outputs 0, state IDLE, prio_last=1; a fresh request is granted normally afterward.

Source files
------------

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port between the icache (req 0) and
// dcache (req 1) refill paths; one burst in flight, beats counted internally.
module ysyx_22050019_axi_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            s_ar_valid_i,
  output logic [1:0]            s_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr0_i,
  input  logic [ADDR_WIDTH-1:0] s_ar_addr1_i,
  input  logic [LEN_WIDTH-1:0]  s_ar_len0_i,
  input  logic [LEN_WIDTH-1:0]  s_ar_len1_i,
  input  logic [1:0]            s_r_ready_i,
  output logic [1:0]            s_r_valid_o,
  output logic [1:0]            s_r_last_o,
  output logic [1:0]            s_r_resp_o,
  output logic [DATA_WIDTH-1:0] s_r_data_o,
  output logic                  m_ar_valid_o,
  input  logic                  m_ar_ready_i,
  output logic [ADDR_WIDTH-1:0] m_ar_addr_o,
  output logic [LEN_WIDTH-1:0]  m_ar_len_o,
  input  logic                  m_r_valid_i,
  output logic                  m_r_ready_o,
  input  logic [1:0]            m_r_resp_i,
  input  logic [DATA_WIDTH-1:0] m_r_data_i,
  input  logic                  m_r_last_i,
  output logic                  proto_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic                  grant_r;
  logic                  prio_last_r;
  logic                  winner_s;
  logic                  beat_s;
  logic                  cnt_zero_s;
  logic                  req_take_s;
  logic                  proto_err_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  cnt_r;

  assign cnt_zero_s  = (cnt_r == {LEN_WIDTH{1'b0}});
  assign req_take_s  = (state_r == IDLE) && (s_ar_valid_i != 2'b00);
  assign beat_s      = (state_r == R) && m_r_valid_i && s_r_ready_i[grant_r];
  assign m_ar_addr_o = addr_r;
  assign m_ar_len_o  = len_r;
  assign s_r_data_o  = m_r_data_i;
  assign s_r_resp_o  = m_r_resp_i;
  assign proto_err_o = proto_err_r;

  // Winner selection: on a tie the requester that did not finish last wins.
  always_comb begin
    winner_s = 1'b0;
    case (s_ar_valid_i)
      2'b01:   winner_s = 1'b0;
      2'b10:   winner_s = 1'b1;
      2'b11:   winner_s = ~prio_last_r;
      default: winner_s = 1'b0;
    endcase
  end

  // Next-state logic and channel routing.
  always_comb begin
    state_s      = state_r;
    s_ar_ready_o = 2'b00;
    s_r_valid_o  = 2'b00;
    s_r_last_o   = 2'b00;
    m_ar_valid_o = 1'b0;
    m_r_ready_o  = 1'b0;
    case (state_r)
      IDLE: begin
        if (s_ar_valid_i != 2'b00) begin
          s_ar_ready_o[winner_s] = 1'b1;
          state_s                = AR;
        end else begin
          state_s = IDLE;
        end
      end
      AR: begin
        m_ar_valid_o = 1'b1;
        if (m_ar_ready_i) begin
          state_s = R;
        end else begin
          state_s = AR;
        end
      end
      R: begin
        s_r_valid_o[grant_r] = m_r_valid_i;
        m_r_ready_o          = s_r_ready_i[grant_r];
        s_r_last_o[grant_r]  = cnt_zero_s & m_r_valid_i;
        // Completion follows the internal count, never m_r_last_i.
        if (beat_s && cnt_zero_s) begin
          state_s = IDLE;
        end else begin
          state_s = R;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, request latch, beat counter and protocol-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_r     <= 1'b0;
      prio_last_r <= 1'b1;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      len_r       <= {LEN_WIDTH{1'b0}};
      cnt_r       <= {LEN_WIDTH{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      proto_err_r <= beat_s && (m_r_last_i != cnt_zero_s);
      if (req_take_s) begin
        grant_r <= winner_s;
        addr_r  <= winner_s ? s_ar_addr1_i : s_ar_addr0_i;
        len_r   <= winner_s ? s_ar_len1_i : s_ar_len0_i;
        cnt_r   <= winner_s ? s_ar_len1_i : s_ar_len0_i;
      end else if (beat_s) begin
        if (!cnt_zero_s) begin
          cnt_r <= cnt_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          prio_last_r <= grant_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arbiter.sv
// Self-checking bench: directed scenarios plus randomized bursts checked against
// a transaction-level round-robin model.
module tb_ysyx_22050019_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_ar_valid_i, s_ar_ready_o;
  logic [31:0] s_ar_addr0_i, s_ar_addr1_i;
  logic [7:0]  s_ar_len0_i, s_ar_len1_i;
  logic [1:0]  s_r_ready_i, s_r_valid_o, s_r_last_o, s_r_resp_o;
  logic [63:0] s_r_data_o;
  logic        m_ar_valid_o, m_ar_ready_i;
  logic [31:0] m_ar_addr_o;
  logic [7:0]  m_ar_len_o;
  logic        m_r_valid_i, m_r_ready_o;
  logic [1:0]  m_r_resp_i;
  logic [63:0] m_r_data_i;
  logic        m_r_last_i, proto_err_o;

  int checks = 0;
  int errors = 0;
  bit last_w = 1'b1;  // model: requester that completed the most recent burst

  ysyx_22050019_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
    .s_ar_addr0_i(s_ar_addr0_i), .s_ar_addr1_i(s_ar_addr1_i),
    .s_ar_len0_i(s_ar_len0_i), .s_ar_len1_i(s_ar_len1_i),
    .s_r_ready_i(s_r_ready_i), .s_r_valid_o(s_r_valid_o),
    .s_r_last_o(s_r_last_o), .s_r_resp_o(s_r_resp_o), .s_r_data_o(s_r_data_o),
    .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
    .m_ar_addr_o(m_ar_addr_o), .m_ar_len_o(m_ar_len_o),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o),
    .m_r_resp_i(m_r_resp_i), .m_r_data_i(m_r_data_i),
    .m_r_last_i(m_r_last_i), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ar_ready"}, s_ar_ready_o, 2'b00);
    chk({tag, "_r_valid"}, s_r_valid_o, 2'b00);
    chk({tag, "_r_last"}, s_r_last_o, 2'b00);
    chk({tag, "_m_ar_valid"}, m_ar_valid_o, 1'b0);
    chk({tag, "_m_r_ready"}, m_r_ready_o, 1'b0);
    chk({tag, "_proto_err"}, proto_err_o, 1'b0);
  endtask

  // One complete transaction: request, address phase with ar_delay stall cycles,
  // then len+1 beats. bp = leading cycles with the granted ready low, rnd = random
  // valid/ready, err_beat = beat index whose m_r_last_i is deliberately wrong.
  task automatic burst(input logic [1:0] vmask, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] l0, input logic [7:0] l1, input int ar_delay,
                       input int bp, input bit rnd, input int err_beat);
    bit          w;
    logic [1:0]  wmask;
    logic [31:0] ea;
    logic [7:0]  el;
    logic        v, r;
    bit          pend;
    int          n, cyc;
    w     = (vmask == 2'b11) ? ~last_w : vmask[1];
    wmask = (w ? 2'b10 : 2'b01);
    ea    = w ? a1 : a0;
    el    = w ? l1 : l0;
    s_ar_valid_i = vmask;
    s_ar_addr0_i = a0; s_ar_addr1_i = a1;
    s_ar_len0_i  = l0; s_ar_len1_i  = l1;
    @(negedge clk);
    chk("idle_grant", s_ar_ready_o, wmask);
    chk("idle_no_m_ar", m_ar_valid_o, 1'b0);
    @(posedge clk); #1;
    s_ar_valid_i = vmask & ~wmask;  // loser stays pending
    for (int d = 0; d <= ar_delay; d++) begin
      m_ar_ready_i = (d == ar_delay);
      @(negedge clk);
      chk("ar_valid", m_ar_valid_o, 1'b1);
      chk("ar_addr", m_ar_addr_o, ea);
      chk("ar_len", m_ar_len_o, el);
      chk("ar_no_ready", s_ar_ready_o, 2'b00);
      @(posedge clk); #1;
    end
    m_ar_ready_i = 1'b0;
    n = 0; cyc = 0; pend = 1'b0;
    while (n <= int'(el) && cyc < 2000) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      r = (cyc < bp) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      m_r_valid_i = v;
      m_r_data_i  = {$urandom, $urandom};
      m_r_resp_i  = 2'($urandom_range(0, 3));
      m_r_last_i  = (n == int'(el)) ^ (n == err_beat);
      s_r_ready_i = w ? {r, ~r} : {~r, r};
      @(negedge clk);
      chk("r_valid", s_r_valid_o, w ? {v, 1'b0} : {1'b0, v});
      chk("r_ready", m_r_ready_o, r);
      chk("r_last", s_r_last_o, ((n == int'(el)) && v) ? wmask : 2'b00);
      chk("r_data", s_r_data_o, m_r_data_i);
      chk("r_resp", s_r_resp_o, m_r_resp_i);
      chk("r_no_ar_ready", s_ar_ready_o, 2'b00);
      chk("proto_err", proto_err_o, pend);
      pend = 1'b0;
      if (v && r) begin
        pend = (n == err_beat);
        n++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (n <= int'(el)) chk("burst_timeout", n, int'(el) + 1);
    m_r_valid_i = 1'b0; m_r_last_i = 1'b0;
    s_ar_valid_i = 2'b00; s_r_ready_i = 2'b00;
    @(negedge clk);
    chk("end_proto_err", proto_err_o, pend);
    chk("end_m_ar_valid", m_ar_valid_o, 1'b0);
    chk("end_r_valid", s_r_valid_o, 2'b00);
    chk("end_ar_ready", s_ar_ready_o, 2'b00);
    @(posedge clk); #1;
    last_w = w;
  endtask

  initial begin
    rst = 1'b1;
    s_ar_valid_i = 2'b00; s_ar_addr0_i = 32'h0; s_ar_addr1_i = 32'h0;
    s_ar_len0_i = 8'h0; s_ar_len1_i = 8'h0; s_r_ready_i = 2'b00;
    m_ar_ready_i = 1'b0; m_r_valid_i = 1'b0; m_r_resp_i = 2'b00;
    m_r_data_i = 64'h0; m_r_last_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    last_w = 1'b1;

    // Tie out of reset and continuous contention: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) burst(2'b11, 32'h100, 32'h200, 8'd0, 8'd0, 0, 0, 1'b0, -1);
    // Single icache two-beat burst.
    burst(2'b01, 32'h8000_0010, 32'h0, 8'd1, 8'd0, 0, 0, 1'b0, -1);
    // Dcache len=3 with three cycles of backpressure.
    burst(2'b10, 32'h0, 32'h4000_0040, 8'd0, 8'd3, 0, 3, 1'b0, -1);
    // Address channel stalled for five cycles, other requester pending.
    burst(2'b11, 32'h1234_5678, 32'h9abc_def0, 8'd2, 8'd1, 5, 0, 1'b0, -1);
    // Early last on beat 1 of a len=1 burst.
    burst(2'b01, 32'h2000, 32'h0, 8'd1, 8'd0, 0, 0, 1'b0, 0);
    // Full-range length.
    burst(2'b10, 32'h0, 32'h3000, 8'd0, 8'd255, 1, 0, 1'b0, -1);

    // Reset in the middle of a dcache burst.
    s_ar_valid_i = 2'b10; s_ar_addr1_i = 32'h5000; s_ar_len1_i = 8'd5;
    @(posedge clk); #1;
    s_ar_valid_i = 2'b00; m_ar_ready_i = 1'b1;
    @(posedge clk); #1;
    m_ar_ready_i = 1'b0; m_r_valid_i = 1'b1; s_r_ready_i = 2'b10;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0; m_r_valid_i = 1'b0; s_r_ready_i = 2'b00;
    last_w = 1'b1;
    burst(2'b11, 32'h600, 32'h700, 8'd1, 8'd2, 0, 0, 1'b0, -1);

    // Randomized traffic against the rotation model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] l0r, l1r;
      logic [1:0] vm;
      int         eb;
      vm  = 2'($urandom_range(1, 3));
      l0r = 8'($urandom_range(0, 7));
      l1r = 8'($urandom_range(0, 7));
      eb  = -1;
      if ($urandom_range(0, 3) == 0) eb = $urandom_range(0, 7);
      burst(vm, $urandom, $urandom, l0r, l1r, $urandom_range(0, 3), 0, 1'b1, eb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
